// File: rtl/router_arb_pkg.sv
// rtl/router_arb_pkg.sv - shared types and widths for the router ingress arbiter
//
// Purpose: FSM state encoding, router field widths and an index-width helper
//          shared by the ingress arbiter and its round-robin picker.
// Ports:   none (package).

package router_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } arb_state_t;

   localparam int HDR_W  = 6;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;

   // Width of an index into an n-entry vector; never zero so a 1-entry
   // vector still gets a legal declaration.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/router_rr_pick.sv
// rtl/router_rr_pick.sv - combinational round-robin requester picker
//
// Purpose: selects the first asserted request at or after last+1 (mod N_REQ).
// Ports:
//   i_req   - request vector, one bit per requester
//   i_last  - index of the most recently served requester
//   o_gnt   - one-hot vector of the picked requester (zero if none)
//   o_idx   - index of the picked requester (zero if none)
//   o_valid - at least one request is asserted

module router_rr_pick
   import router_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_last,
   output logic [N_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_valid
);

   // Walk the ring starting just after the last winner; the first hit wins,
   // so the last winner itself is considered only after everyone else.
   always_comb begin
      int c;
      c       = 0;
      o_gnt   = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         c = (int'(i_last) + k) % N_REQ;
         if (!o_valid && i_req[c]) begin
            o_valid  = 1'b1;
            o_idx    = IDX_W'(c);
            o_gnt[c] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/router_ingress_arbiter.sv
// rtl/router_ingress_arbiter.sv - round-robin sharing of one router packet ingress
//
// Purpose: grants one of N_REQ requesters at a time while the router is ready,
//          presents the latched packet on the router ingress, waits for the
//          checksum verdict (or a timeout) and returns a one-cycle completion
//          pulse with result. Keeps saturating ok/fail/timeout statistics.
// Ports:
//   i_clk, i_reset                   - clock, synchronous active-high reset
//   i_req                            - per-requester packet pending
//   i_req_header/address/data        - per-requester packet fields, slice i
//   o_gnt                            - one-hot, high from grant until done
//   o_done, o_done_ok, o_done_timeout - one-cycle completion pulse and result
//   i_rtr_ready/ack_out/bad_packet   - router status
//   o_rtr_receive/header/address/data - router ingress drive
//   o_cnt_ok, o_cnt_fail, o_cnt_timeout - saturating statistics

module router_ingress_arbiter
   import router_arb_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic [N_REQ-1:0]          i_req,
   input  logic [N_REQ*HDR_W-1:0]    i_req_header,
   input  logic [N_REQ*ADDR_W-1:0]   i_req_address,
   input  logic [N_REQ*DATA_W-1:0]   i_req_data,
   output logic [N_REQ-1:0]          o_gnt,
   output logic [N_REQ-1:0]          o_done,
   output logic                      o_done_ok,
   output logic                      o_done_timeout,
   input  logic                      i_rtr_ready,
   input  logic                      i_rtr_ack_out,
   input  logic                      i_rtr_bad_packet,
   output logic                      o_rtr_receive,
   output logic [HDR_W-1:0]          o_rtr_header,
   output logic [ADDR_W-1:0]         o_rtr_address,
   output logic [DATA_W-1:0]         o_rtr_data,
   output logic [CNT_W-1:0]          o_cnt_ok,
   output logic [CNT_W-1:0]          o_cnt_fail,
   output logic [CNT_W-1:0]          o_cnt_timeout
);

   localparam int IDX_W = idx_w(N_REQ);
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   arb_state_t        r_state;
   arb_state_t        w_next;

   logic [IDX_W-1:0]  r_last;
   logic [IDX_W-1:0]  r_gidx;
   logic [N_REQ-1:0]  r_gnt;
   logic [N_REQ-1:0]  r_done;
   logic              r_done_ok;
   logic              r_done_timeout;
   logic              r_receive;
   logic [HDR_W-1:0]  r_hdr;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [TMR_W-1:0]  r_timer;
   logic [CNT_W-1:0]  r_cnt_ok;
   logic [CNT_W-1:0]  r_cnt_fail;
   logic [CNT_W-1:0]  r_cnt_timeout;

   logic [N_REQ-1:0]  w_pick_gnt;
   logic [IDX_W-1:0]  w_pick_idx;
   logic              w_pick_valid;
   logic              w_tmo;
   logic              w_grant;
   logic              w_finish;
   logic              w_fin_ok;
   logic              w_fin_to;

   router_rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .i_req   (i_req),
      .i_last  (r_last),
      .o_gnt   (w_pick_gnt),
      .o_idx   (w_pick_idx),
      .o_valid (w_pick_valid)
   );

   assign w_tmo = (r_timer == TMR_LAST);

   // Next state and one-cycle control strobes for the datapath.
   always_comb begin
      w_next   = r_state;
      w_grant  = 1'b0;
      w_finish = 1'b0;
      w_fin_ok = 1'b0;
      w_fin_to = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_rtr_ready && w_pick_valid) begin
               w_grant = 1'b1;
               w_next  = SEND;
            end
         end
         SEND: begin
            // A router that never leaves READY would otherwise pin us here.
            if (w_tmo) begin
               w_finish = 1'b1;
               w_fin_to = 1'b1;
            end else if (!i_rtr_ready) begin
               w_next = WAIT;
            end
         end
         WAIT: begin
            // bad_packet takes precedence over ack_out; any verdict beats
            // a timeout landing in the same cycle.
            if (i_rtr_bad_packet) begin
               w_finish = 1'b1;
            end else if (i_rtr_ack_out) begin
               w_finish = 1'b1;
               w_fin_ok = 1'b1;
            end else if (w_tmo) begin
               w_finish = 1'b1;
               w_fin_to = 1'b1;
            end
         end
         RESP: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
      if (w_finish) begin
         w_next = RESP;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Datapath: all outputs are registered, so results are loaded on the
   // edge that enters RESP and are visible for the single RESP cycle.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_last         <= LAST_RST;
         r_gidx         <= '0;
         r_gnt          <= '0;
         r_done         <= '0;
         r_done_ok      <= 1'b0;
         r_done_timeout <= 1'b0;
         r_receive      <= 1'b0;
         r_hdr          <= '0;
         r_addr         <= '0;
         r_data         <= '0;
         r_timer        <= '0;
         r_cnt_ok       <= '0;
         r_cnt_fail     <= '0;
         r_cnt_timeout  <= '0;
      end else begin
         r_done         <= '0;
         r_done_ok      <= 1'b0;
         r_done_timeout <= 1'b0;
         r_receive      <= (w_next == SEND);

         if (r_state == SEND || r_state == WAIT) begin
            r_timer <= r_timer + TMR_W'(1);
         end

         if (w_grant) begin
            r_gnt   <= w_pick_gnt;
            r_gidx  <= w_pick_idx;
            r_hdr   <= i_req_header[w_pick_idx*HDR_W +: HDR_W];
            r_addr  <= i_req_address[w_pick_idx*ADDR_W +: ADDR_W];
            r_data  <= i_req_data[w_pick_idx*DATA_W +: DATA_W];
            r_timer <= '0;
         end

         if (w_finish) begin
            r_gnt          <= '0;
            r_done         <= r_gnt;
            r_done_ok      <= w_fin_ok;
            r_done_timeout <= w_fin_to;
            r_last         <= r_gidx;
            if (w_fin_ok) begin
               if (r_cnt_ok != CNT_MAX) r_cnt_ok <= r_cnt_ok + CNT_W'(1);
            end else if (w_fin_to) begin
               if (r_cnt_timeout != CNT_MAX) r_cnt_timeout <= r_cnt_timeout + CNT_W'(1);
            end else begin
               if (r_cnt_fail != CNT_MAX) r_cnt_fail <= r_cnt_fail + CNT_W'(1);
            end
         end
      end
   end

   assign o_gnt          = r_gnt;
   assign o_done         = r_done;
   assign o_done_ok      = r_done_ok;
   assign o_done_timeout = r_done_timeout;
   assign o_rtr_receive  = r_receive;
   assign o_rtr_header   = r_hdr;
   assign o_rtr_address  = r_addr;
   assign o_rtr_data     = r_data;
   assign o_cnt_ok       = r_cnt_ok;
   assign o_cnt_fail     = r_cnt_fail;
   assign o_cnt_timeout  = r_cnt_timeout;

endmodule

// File: tb/tb_router_ingress_arbiter.sv
// tb/tb_router_ingress_arbiter.sv - self-checking bench for router_ingress_arbiter

module tb_router_ingress_arbiter;

   localparam int N_REQ   = 4;
   localparam int TIMEOUT = 8;
   localparam int CNT_W   = 3;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [N_REQ-1:0]      req;
   logic [N_REQ*6-1:0]    req_header;
   logic [N_REQ*12-1:0]   req_address;
   logic [N_REQ*32-1:0]   req_data;
   logic [N_REQ-1:0]      gnt;
   logic [N_REQ-1:0]      done;
   logic                  done_ok;
   logic                  done_timeout;
   logic                  rtr_ready;
   logic                  rtr_ack_out;
   logic                  rtr_bad_packet;
   logic                  rtr_receive;
   logic [5:0]            rtr_header;
   logic [11:0]           rtr_address;
   logic [31:0]           rtr_data;
   logic [CNT_W-1:0]      cnt_ok;
   logic [CNT_W-1:0]      cnt_fail;
   logic [CNT_W-1:0]      cnt_timeout;

   always #5 clk = ~clk;

   router_ingress_arbiter #(
      .N_REQ   (N_REQ),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .i_clk            (clk),
      .i_reset          (reset),
      .i_req            (req),
      .i_req_header     (req_header),
      .i_req_address    (req_address),
      .i_req_data       (req_data),
      .o_gnt            (gnt),
      .o_done           (done),
      .o_done_ok        (done_ok),
      .o_done_timeout   (done_timeout),
      .i_rtr_ready      (rtr_ready),
      .i_rtr_ack_out    (rtr_ack_out),
      .i_rtr_bad_packet (rtr_bad_packet),
      .o_rtr_receive    (rtr_receive),
      .o_rtr_header     (rtr_header),
      .o_rtr_address    (rtr_address),
      .o_rtr_data       (rtr_data),
      .o_cnt_ok         (cnt_ok),
      .o_cnt_fail       (cnt_fail),
      .o_cnt_timeout    (cnt_timeout)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic fail_line(input string name, input int act, input int exp);
      n_chk++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Router stub: 0 = checksum verdict, 1 = mute (stays ready, never answers),
   // 2 = ack_out and bad_packet together.
   int stub_mode     = 0;
   int stub_send_dly = 1;
   int stub_vdly     = 1;

   initial begin
      logic [5:0]  h;
      logic [31:0] d;
      bit          good;
      rtr_ready      = 1'b1;
      rtr_ack_out    = 1'b0;
      rtr_bad_packet = 1'b0;
      forever begin
         @(negedge clk);
         if (rtr_receive && stub_mode != 1) begin
            h = rtr_header;
            d = rtr_data;
            repeat (stub_send_dly - 1) @(negedge clk);
            rtr_ready = 1'b0;
            repeat (stub_vdly) @(negedge clk);
            good = ($countones(d) == int'(h));
            if (stub_mode == 2) begin
               rtr_ack_out    = 1'b1;
               rtr_bad_packet = 1'b1;
            end else begin
               rtr_ack_out    = good;
               rtr_bad_packet = !good;
            end
            @(negedge clk);
            rtr_ack_out    = 1'b0;
            rtr_bad_packet = 1'b0;
            rtr_ready      = 1'b1;
         end
      end
   end

   // Scoreboard of expected completions, consumed when done pulses.
   typedef struct packed {
      logic [N_REQ-1:0] d;
      logic             ok;
      logic             to;
   } exp_t;
   exp_t sb[$];

   int               cyc = 0, n_gnt = 0, n_done = 0, gnt_cyc = 0, done_cyc = 0, rx_cnt = 0;
   logic [N_REQ-1:0] prev_gnt = '0;
   logic             prev_rx  = 1'b0;
   logic [5:0]       rx_hdr;
   logic [11:0]      rx_addr;
   logic [31:0]      rx_data;
   logic [N_REQ-1:0] gnt_log[$];

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (gnt != '0 && prev_gnt == '0) begin
            n_gnt++;
            gnt_cyc = cyc;
            gnt_log.push_back(gnt);
         end
         if (rtr_receive) begin
            if (!prev_rx) begin
               rx_cnt  = 1;
               rx_hdr  = rtr_header;
               rx_addr = rtr_address;
               rx_data = rtr_data;
            end else begin
               rx_cnt++;
            end
         end
         if (done != '0) begin
            n_done++;
            done_cyc = cyc;
            if (sb.size() == 0) begin
               fail_line("unexpected_done", int'(done), 0);
            end else begin
               e = sb.pop_front();
               check("done", done, e.d);
               check("done_ok", done_ok, e.ok);
               check("done_timeout", done_timeout, e.to);
            end
         end
         prev_gnt = gnt;
         prev_rx  = rtr_receive;
      end
   end

   task automatic wait_gnt(input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clk); #1;
         if (gnt != '0) break;
      end
      if (k == budget) fail_line("wait_gnt_cycles", k, budget - 1);
   endtask

   task automatic wait_gnt_n(input int target, input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clk); #1;
         if (n_gnt >= target) break;
      end
      if (k == budget) fail_line("wait_gnt_count", n_gnt, target);
   endtask

   task automatic wait_done_n(input int target, input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clk); #1;
         if (n_done >= target) break;
      end
      if (k == budget) fail_line("wait_done_count", n_done, target);
   endtask

   task automatic wait_rx_low(input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clk); #1;
         if (!rtr_receive) break;
      end
      if (k == budget) fail_line("wait_receive_low", k, budget - 1);
   endtask

   task automatic wait_idle(input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clk); #1;
         if (rtr_ready && gnt == '0 && !rtr_receive && done == '0) break;
      end
      if (k == budget) fail_line("wait_idle", k, budget - 1);
   endtask

   function automatic int sat(input int x);
      return (x < CNT_MAX) ? x + 1 : x;
   endfunction

   int exp_ok = 0, exp_fail = 0, exp_to = 0;

   task automatic check_cnts(input string tag);
      check({tag, "_cnt_ok"}, cnt_ok, exp_ok);
      check({tag, "_cnt_fail"}, cnt_fail, exp_fail);
      check({tag, "_cnt_timeout"}, cnt_timeout, exp_to);
   endtask

   typedef struct {
      int               idx;
      logic [5:0]       hdr;
      logic [11:0]      addr;
      logic [31:0]      data;
      int               mode;
      int               sdly;
      logic [N_REQ-1:0] edone;
      logic             eok;
      logic             eto;
      int               erx;
   } vec_t;

   initial begin
      vec_t             tbl[6];
      logic [N_REQ-1:0] rr_exp[5];
      int               base_g, base_d;

      reset       = 1'b1;
      req         = '0;
      req_header  = '0;
      req_address = '0;
      req_data    = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_gnt", gnt, 4'b0000);
      check("rst_done", done, 4'b0000);
      check("rst_done_ok", done_ok, 1'b0);
      check("rst_done_timeout", done_timeout, 1'b0);
      check("rst_receive", rtr_receive, 1'b0);
      check("rst_header", rtr_header, 6'd0);
      check("rst_address", rtr_address, 12'd0);
      check("rst_data", rtr_data, 32'd0);
      check_cnts("rst");
      reset = 1'b0;

      //          idx hdr    addr     data           mode sdly done     ok    to    rx
      tbl[0] = '{2, 6'd32, 12'hf0f, 32'hFFFF_FFFF, 0, 2, 4'b0100, 1'b1, 1'b0, 2};
      tbl[1] = '{0, 6'd13, 12'h123, 32'h0000_0FFF, 0, 1, 4'b0001, 1'b0, 1'b0, 1};
      tbl[2] = '{1, 6'd0,  12'h000, 32'h0000_0000, 0, 1, 4'b0010, 1'b1, 1'b0, 1};
      tbl[3] = '{0, 6'd1,  12'hfff, 32'h8000_0000, 0, 1, 4'b0001, 1'b1, 1'b0, 1};
      tbl[4] = '{1, 6'd16, 12'h0a5, 32'h5555_5555, 1, 1, 4'b0010, 1'b0, 1'b1, TIMEOUT};
      tbl[5] = '{3, 6'd16, 12'h5a0, 32'h5555_5555, 2, 1, 4'b1000, 1'b0, 1'b0, 1};

      foreach (tbl[i]) begin
         wait_idle(30);
         stub_mode     = tbl[i].mode;
         stub_send_dly = tbl[i].sdly;
         stub_vdly     = 1;
         req_header    = 24'($urandom);
         req_address   = {$urandom, $urandom};
         req_data      = {$urandom, $urandom, $urandom, $urandom};
         req_header[tbl[i].idx*6 +: 6]   = tbl[i].hdr;
         req_address[tbl[i].idx*12 +: 12] = tbl[i].addr;
         req_data[tbl[i].idx*32 +: 32]   = tbl[i].data;
         sb.push_back('{tbl[i].edone, tbl[i].eok, tbl[i].eto});
         base_d = n_done;
         req    = 4'(1 << tbl[i].idx);
         wait_gnt(10);
         check($sformatf("v%0d_gnt", i), gnt, tbl[i].edone);
         req = '0;
         wait_done_n(base_d + 1, TIMEOUT + 20);
         check($sformatf("v%0d_rx_cycles", i), rx_cnt, tbl[i].erx);
         check($sformatf("v%0d_rtr_header", i), rx_hdr, tbl[i].hdr);
         check($sformatf("v%0d_rtr_address", i), rx_addr, tbl[i].addr);
         check($sformatf("v%0d_rtr_data", i), rx_data, tbl[i].data);
         if (tbl[i].eto) check($sformatf("v%0d_timeout_latency", i), done_cyc - gnt_cyc, TIMEOUT);
         if (tbl[i].eok) exp_ok = sat(exp_ok);
         else if (tbl[i].eto) exp_to = sat(exp_to);
         else exp_fail = sat(exp_fail);
         check_cnts($sformatf("v%0d", i));
      end

      // Round-robin with all requesters pending; last winner was 3.
      wait_idle(30);
      stub_mode     = 0;
      stub_send_dly = 1;
      for (int r = 0; r < N_REQ; r++) begin
         req_header[r*6 +: 6]  = 6'd16;
         req_data[r*32 +: 32]  = 32'h5555_5555;
      end
      rr_exp[0] = 4'b0001;
      rr_exp[1] = 4'b0010;
      rr_exp[2] = 4'b0100;
      rr_exp[3] = 4'b1000;
      rr_exp[4] = 4'b0001;
      for (int r = 0; r < 5; r++) sb.push_back('{rr_exp[r], 1'b1, 1'b0});
      gnt_log.delete();
      base_g = n_gnt;
      base_d = n_done;
      req    = 4'b1111;
      wait_gnt_n(base_g + 5, 60);
      req = '0;
      wait_done_n(base_d + 5, 40);
      check("rr_grant_count", gnt_log.size(), 5);
      for (int r = 0; r < 5; r++) begin
         if (r < gnt_log.size()) check($sformatf("rr_order_%0d", r), gnt_log[r], rr_exp[r]);
         else fail_line($sformatf("rr_order_%0d_missing", r), gnt_log.size(), r + 1);
      end
      for (int r = 0; r < 5; r++) exp_ok = sat(exp_ok);
      check_cnts("rr_sat");

      // Reset while waiting for the verdict.
      wait_idle(30);
      stub_vdly = 4;
      req_header[2*6 +: 6]  = 6'd16;
      req_data[2*32 +: 32]  = 32'h5555_5555;
      req = 4'b0100;
      wait_gnt(10);
      check("mid_gnt", gnt, 4'b0100);
      req = '0;
      wait_rx_low(10);
      check("mid_in_wait_gnt", gnt, 4'b0100);
      reset = 1'b1;
      @(negedge clk); #1;
      check("mid_rst_receive", rtr_receive, 1'b0);
      check("mid_rst_gnt", gnt, 4'b0000);
      check("mid_rst_done", done, 4'b0000);
      exp_ok   = 0;
      exp_fail = 0;
      exp_to   = 0;
      check_cnts("mid_rst");
      reset = 1'b0;
      wait_idle(30);
      repeat (3) @(negedge clk);
      #1;
      stub_vdly = 1;
      req_header[0*6 +: 6]  = 6'd16;
      req_data[0*32 +: 32]  = 32'h5555_5555;
      sb.push_back('{4'b0001, 1'b1, 1'b0});
      base_d = n_done;
      req    = 4'b0101;
      wait_gnt(10);
      check("post_rst_gnt", gnt, 4'b0001);
      req = '0;
      wait_done_n(base_d + 1, 20);
      exp_ok = sat(exp_ok);
      check_cnts("post_rst");

      wait_idle(30);
      check("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
